// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 8N1 serial receiver sampling mid-bit, one-cycle valid strobe per framed byte
module uart_rx_sampler #(
  parameter int FREQUENCY = 50000000,
  parameter int BAUD      = 19200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int DIV  = (FREQUENCY + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  generate
    if (DIV < 8) begin : g_div_check
      $error("uart_rx_sampler: FREQUENCY/BAUD must give at least 8 clocks per bit");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rxs;

  assign rxs = sync[1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      sync    <= 2'b11;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= 8'h00;
      valid   <= 1'b0;
    end else begin
      sync  <= {sync[0], rx};
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        // Re-check the start bit at its centre; a high line here was a glitch.
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == DIV_M1) begin
            cnt     <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leave at mid stop bit so a start bit directly behind it is not missed.
        S_STOP: begin
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (rxs) begin
              data  <= shift;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - scoreboard bench for uart_rx_sampler at DIV=32
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;

  uart_rx_sampler #(.FREQUENCY(614400), .BAUD(19200)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .data  (data),
    .valid (valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_lat = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int vcount = 0;
  int npush = 0;
  bit mon_en = 1'b0;
  logic valid_d = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid === 1'b1) begin
        vcount++;
        prev_vcyc = last_vcyc;
        last_vcyc = cyc;
        last_lat  = cyc - start_cyc;
        chk("valid_1cyc", {31'd0, valid_d}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
        else chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      valid_d = valid;
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v);
    start_cyc = cyc;
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(b[i], per);
    drive(stop_v, per);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    npush++;
  endtask

  initial begin
    int vc;
    logic [7:0] rb;
    rb = 8'hF5;
    drive(1'b1, 4);
    rstn = 1'b1;
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    mon_en = 1'b1;
    drive(1'b1, 10);

    expect_byte(8'h55);
    send_frame(8'h55, 32, 1'b1);
    drive(1'b1, 40);
    chk("pulses_55", vcount, 1);
    chk("lat_306_pm1", {31'd0, (last_lat >= 305 && last_lat <= 307)}, 32'd1);

    expect_byte(8'hA3);
    expect_byte(8'h0F);
    send_frame(8'hA3, 32, 1'b1);
    send_frame(8'h0F, 32, 1'b1);
    drive(1'b1, 40);
    chk("pulses_b2b", vcount, 3);
    chk("gap_320_pm2", {31'd0, ((last_vcyc - prev_vcyc) >= 318 && (last_vcyc - prev_vcyc) <= 322)}, 32'd1);

    vc = vcount;
    drive(1'b0, 5);
    drive(1'b1, 60);
    chk("glitch_pulses", vcount, vc);
    chk("glitch_data", {24'd0, data}, 32'h0F);
    expect_byte(8'h7E);
    send_frame(8'h7E, 32, 1'b1);
    drive(1'b1, 40);

    vc = vcount;
    send_frame(8'hC4, 32, 1'b0);
    drive(1'b1, 40);
    chk("frm_err_pulses", vcount, vc);
    chk("frm_err_data", {24'd0, data}, 32'h7E);
    expect_byte(8'h12);
    send_frame(8'h12, 32, 1'b1);
    drive(1'b1, 40);

    vc = vcount;
    drive(1'b0, 32);
    for (int i = 0; i < 4; i++) drive(rb[i], 32);
    drive(rb[4], 16);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("midrst_data", {24'd0, data}, 32'h00);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    drive(rb[4], 15);
    for (int i = 5; i < 8; i++) drive(rb[i], 32);
    drive(1'b1, 72);
    chk("midrst_pulses", vcount, vc);
    chk("midrst_hold", {24'd0, data}, 32'h00);
    expect_byte(8'h99);
    send_frame(8'h99, 32, 1'b1);
    drive(1'b1, 40);

    vc = vcount;
    expect_byte(8'hF0);
    send_frame(8'hF0, 31, 1'b1);
    drive(1'b1, 40);
    chk("tol31_pulses", vcount, vc + 1);
    expect_byte(8'hF0);
    send_frame(8'hF0, 33, 1'b1);
    drive(1'b1, 40);
    chk("tol33_pulses", vcount, vc + 2);

    chk("sb_empty", exp_q.size(), 0);
    chk("pulses_total", vcount, npush);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
